// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a small in-order instruction buffer.
// Requests carry word-aligned PCs; responses return in order and are tagged with
// their PC on entry to the buffer. Redirects flush the buffer and discard any
// responses still in flight.
// Optional feature: define FETCH_ILLEGAL_CHECK_EN to add the inst_illegal output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [6:0]  inst_opcode
`ifdef FETCH_ILLEGAL_CHECK_EN
  ,
  output logic        inst_illegal
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nxt;
  logic           run;
  logic [31:0]    pc;
  logic [31:0]    rsp_pc;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  outstanding_nxt;
  logic [CW-1:0]  drop_cnt;
  logic [CW-1:0]  count;
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [31:0]    data_q [FIFO_DEPTH];
  logic [31:0]    pc_q   [FIFO_DEPTH];
  logic           pop, req_fire, rsp_accept, rsp_drop, fifo_wr, fifo_rd;
  logic [31:0]    redirect_target;
  logic           unused_ok;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_ok       = &{1'b0, redirect_pc[1:0]};

  // State register: IDLE is held in reset and left on the first clock afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: IDLE always moves to RUN, RUN is sticky until the next reset.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output: fetching is only enabled while running.
  always_comb begin
    run = (state == RUN);
  end

  // Handshake decode; a consume this cycle frees a slot so the pipeline can stream at one per cycle.
  always_comb begin
    pop             = inst_valid && inst_ready;
    imem_req_valid  = run && ((outstanding + count - CW'(pop)) < DEPTH_C);
    imem_addr       = pc;
    req_fire        = imem_req_valid && imem_req_ready;
    rsp_accept      = imem_rsp_valid && (outstanding != '0);
    rsp_drop        = rsp_accept && (drop_cnt != '0);
    fifo_wr         = rsp_accept && !rsp_drop && !redirect_valid;
    fifo_rd         = pop && !redirect_valid;
    outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_accept);
  end

  // Fetch PC: a redirect wins over an accepted request, which advances by one word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_target;
    else if (req_fire)       pc <= pc + 32'd4;
  end

  // PC of the next response that will be kept; responses return in order so one register suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rsp_pc <= RESET_PC;
    else if (redirect_valid) rsp_pc <= redirect_target;
    else if (fifo_wr)        rsp_pc <= rsp_pc + 32'd4;
  end

  // Requests accepted but not yet answered, including ones whose responses will be dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outstanding <= '0;
    else        outstanding <= outstanding_nxt;
  end

  // Drop counter: on redirect every response still owed belongs to the old path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              drop_cnt <= '0;
    else if (redirect_valid) drop_cnt <= outstanding_nxt;
    else if (rsp_drop)       drop_cnt <= drop_cnt - CW'(1);
  end

  // Buffer pointers and occupancy; a redirect empties the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(fifo_wr) - CW'(fifo_rd);
    end
  end

  // Buffer storage: instruction word paired with its fetch address.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      data_q[wr_ptr] <= imem_rsp_data;
      pc_q[wr_ptr]   <= rsp_pc;
    end
  end

  // Head of the buffer drives decode directly; outputs read zero when nothing is buffered.
  always_comb begin
    inst_valid  = (count != '0);
    inst_data   = inst_valid ? data_q[rd_ptr] : 32'd0;
    inst_pc     = inst_valid ? pc_q[rd_ptr]   : 32'd0;
    inst_opcode = inst_data[6:0];
  end

`ifdef FETCH_ILLEGAL_CHECK_EN
  logic opcode_known;

  // Flag buffered words that are not 32-bit encodings or use an unsupported major opcode.
  always_comb begin
    case (inst_opcode)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0001111, 7'b1100111,
      7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111:
        opcode_known = 1'b1;
      default:
        opcode_known = 1'b0;
    endcase
    inst_illegal = inst_valid && ((inst_data[1:0] != 2'b11) || !opcode_known);
  end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: FIFO_DEPTH, 2, instruction buffer entries (power of two, 2..8).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_addr  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  in-order response valid, at least 1 cycle after acceptance.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  branch/jump redirect pulse.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 inst_valid  output  1  buffered instruction available to decode.
REQ-013 inst_ready  input  1  decode consumes instruction.
REQ-014 inst_data  output  32  instruction word.
REQ-015 inst_pc  output  32  address of inst_data.
REQ-016 inst_opcode  output  7  inst_data[6:0], drives control-unit opcode.

Function
REQ-017 Transfers SHALL occur only on valid&&ready cycles, both on the request and on the instruction interface.
REQ-018 While imem_req_valid=1 and not accepted, imem_addr SHALL hold stable unless a redirect occurs.
REQ-019 Outstanding-request counter plus FIFO occupancy SHALL never exceed FIFO_DEPTH; imem_req_valid=1 only when below it and state is RUN.
REQ-020 On request acceptance, fetch PC SHALL advance by 4 with 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-021 Each non-dropped response SHALL be written into the FIFO with its PC; FIFO head SHALL drive inst_* combinationally.
REQ-022 Best-case latency: request accepted cycle N, response cycle N+1, inst_valid=1 in cycle N+2.
REQ-023 Sustained throughput with single-cycle memory and inst_ready=1 SHALL be one instruction per cycle.
REQ-024 Simultaneous FIFO write and read SHALL be allowed when full; occupancy unchanged.
REQ-025 On redirect_valid: FIFO SHALL flush, inst_valid=0 next cycle, fetch PC <= {redirect_pc[31:2],2'b00}, drop counter <= outstanding count (including a request accepted in the same cycle).
REQ-026 Responses arriving while drop counter > 0 SHALL be discarded and decrement it; new requests SHALL proceed in parallel.
REQ-027 Redirect SHALL take priority over every simultaneous event (request accept, response write, consume).
REQ-028 FSM states: IDLE, RUN. IDLE -> RUN one cycle after rst_n deasserts; RUN persists; no requests in IDLE.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, fetch PC RESET_PC, FIFO empty, counters 0.
REQ-030 During reset: imem_req_valid=0, inst_valid=0, imem_addr=RESET_PC, inst_data/inst_pc/inst_opcode=0.
REQ-031 Reset mid-transaction SHALL abandon outstanding requests; responses arriving during or after reset, before the first new request, SHALL be ignored.

Configuration
REQ-032 Macro FETCH_ILLEGAL_CHECK_EN defined: extra output inst_illegal (1 bit), high with inst_valid when inst_data[1:0]!=2'b11 or opcode not in {0110011,0010011,0000011,0001111,1100111,0100011,1100011,0110111,0010111,1101111}; reset value 0.
REQ-033 Macro undefined: inst_illegal port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset release, 1-cycle memory, inst_ready=1 -> imem_addr 0,4,8,... one per cycle; first inst_valid 3 cycles after rst_n rises, inst_pc=0.
REQ-035 inst_ready=0 with FIFO_DEPTH=2 -> exactly 2 requests issued, then imem_req_valid=0 until a consume.
REQ-036 Redirect to 32'h0000_1003 with 2 outstanding -> both stale responses dropped, next inst_pc=32'h0000_1000.
REQ-037 imem_req_ready=0 for 5 cycles -> imem_addr stable, no PC advance.
REQ-038 Fetch at 32'hFFFF_FFFC -> next imem_addr 32'h0000_0000.
REQ-039 FETCH_ILLEGAL_CHECK_EN, response 32'h0000_0000 -> inst_illegal=1; 32'h0000_0013 -> inst_illegal=0.
